// File: rtl/sobel_x_frame_sched_pkg.sv
// Shared types and widths for the Sobel-X frame scheduler.
// Contents:
//   PIX_W   - pixel width fetched from frame memory
//   INT_W   - width of a column intermediate returned by the engine
//   COORD_W - width of the emitted pixel coordinates
//   state_t - scheduler FSM states
package sobel_pkg;

    localparam int PIX_W   = 8;
    localparam int INT_W   = 10;
    localparam int COORD_W = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        CAPT  = 3'd2,
        CALC  = 3'd3,
        EMIT  = 3'd4,
        DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/sobel_x_col_window.sv
// Three-column window of engine intermediates (I0 oldest, I2 newest).
// Ports:
//   clk     - rising-edge clock
//   i_rst   - synchronous active-high reset, clears the window
//   i_clr   - synchronous clear (row advance / frame start)
//   i_shift - shift in i_data: I0 <- I1 <- I2 <- i_data
//   i_data  - new column intermediate
//   o_i0    - intermediate of the left neighbour column
//   o_i2    - intermediate of the right neighbour column
module sobel_x_col_window
    import sobel_pkg::*;
(
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_shift,
    input  logic [INT_W-1:0] i_data,
    output logic [INT_W-1:0] o_i0,
    output logic [INT_W-1:0] o_i2
);

    logic [2:0][INT_W-1:0] r_win;
    logic [2:0][INT_W-1:0] w_src;

    // Each entry loads from its younger neighbour; the newest entry loads i_data.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_src
            if (gi == 2) begin : g_new
                assign w_src[gi] = i_data;
            end else begin : g_old
                assign w_src[gi] = r_win[gi+1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (i_rst || i_clr) begin
            r_win <= '0;
        end else if (i_shift) begin
            r_win <= w_src;
        end
    end

    assign o_i0 = r_win[0];
    assign o_i2 = r_win[2];

endmodule

// File: rtl/sobel_x_frame_sched.sv
// Frame scheduler for the column-sequential Sobel-X engine.
// Fetches three vertical taps per column, streams them into the engine, keeps a
// three-column window of the returned intermediates and emits one result per
// interior pixel over a valid/ready stream.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   start / busy / done      - frame control
//   mem_rd/mem_addr/mem_rdata- frame memory read port (data 1 cycle after mem_rd)
//   dp_*                     - engine interface (pixel taps in, intermediates, result)
//   out_valid/out_ready      - result stream handshake
//   out_data, out_x, out_y   - Sobel-X value and its interior pixel coordinate
module sobel_x_frame_sched
    import sobel_pkg::*;
#(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int ADDR_W = 19,
    parameter int DP_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               mem_rd,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [PIX_W-1:0]   mem_rdata,
    output logic [PIX_W-1:0]   dp_current_in,
    output logic               dp_tap_first,
    input  logic [INT_W-1:0]   dp_current_intermediate,
    output logic [INT_W-1:0]   dp_left_intermediate,
    output logic [INT_W-1:0]   dp_right_intermediate,
    input  logic [INT_W-1:0]   dp_sobel_x_out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INT_W-1:0]   out_data,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y
);

    localparam int                  CNT_W      = $clog2(DP_LAT + 4);
    // Reads occupy counts 0..2; the intermediate is ready DP_LAT cycles after the tap-2 pixel.
    localparam logic [CNT_W-1:0]    FETCH_LAST = CNT_W'(2 + DP_LAT);
    localparam logic [COORD_W-1:0]  COL_LAST   = COORD_W'(IMG_W - 1);
    localparam logic [COORD_W-1:0]  ROW_LAST   = COORD_W'(IMG_H - 2);
    localparam logic [ADDR_W-1:0]   ROW_STRIDE = ADDR_W'(IMG_W);

    state_t               r_state, w_state_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [COORD_W-1:0]   r_col, r_row;
    logic [ADDR_W-1:0]    r_row_base;   // (centre row - 1) * IMG_W
    logic [ADDR_W-1:0]    r_addr;
    logic [1:0]           r_loaded;     // columns in window this row, saturates at 3
    logic                 r_rd_dly, r_first_dly;
    logic [INT_W-1:0]     r_out_data;
    logic [COORD_W-1:0]   r_out_x, r_out_y;

    logic                 w_mem_rd, w_accept, w_row_end, w_last_row;
    logic                 w_win_clr, w_win_shift;
    logic [INT_W-1:0]     w_i0, w_i2;
    logic [ADDR_W-1:0]    w_next_col_addr;

    assign w_mem_rd        = (r_state == FETCH) && (r_cnt < CNT_W'(3));
    assign w_accept        = (r_state == EMIT) && out_ready;
    assign w_row_end       = (r_col == COL_LAST);
    assign w_last_row      = (r_row == ROW_LAST);
    assign w_next_col_addr = r_row_base + ADDR_W'(r_col) + ADDR_W'(1);
    assign w_win_clr       = ((r_state == IDLE) && start) || (w_accept && w_row_end);
    assign w_win_shift     = (r_state == CAPT);

    sobel_x_col_window u_window (
        .clk     (clk),
        .i_rst   (rst),
        .i_clr   (w_win_clr),
        .i_shift (w_win_shift),
        .i_data  (dp_current_intermediate),
        .o_i0    (w_i0),
        .o_i2    (w_i2)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = FETCH;
            FETCH:   if (r_cnt == FETCH_LAST) w_state_next = CAPT;
            CAPT:    w_state_next = (r_loaded >= 2'd2) ? CALC : FETCH;
            CALC:    if (r_cnt == CNT_W'(1)) w_state_next = EMIT;
            EMIT:    if (out_ready) w_state_next = (w_row_end && w_last_row) ? DONE : FETCH;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath: counters, address generation, result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_row_base  <= '0;
            r_addr      <= '0;
            r_loaded    <= '0;
            r_rd_dly    <= 1'b0;
            r_first_dly <= 1'b0;
            r_out_data  <= '0;
            r_out_x     <= '0;
            r_out_y     <= '0;
        end else begin
            r_rd_dly    <= w_mem_rd;
            r_first_dly <= w_mem_rd && (r_cnt == '0);

            if (w_state_next != r_state) begin
                r_cnt <= '0;
            end else if ((r_state == FETCH) || (r_state == CALC)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_row      <= COORD_W'(1);
                        r_col      <= '0;
                        r_row_base <= '0;
                        r_addr     <= '0;
                        r_loaded   <= '0;
                    end
                end
                FETCH: begin
                    // Step down one row per tap; stop after the tap-2 address.
                    if (r_cnt < CNT_W'(2)) r_addr <= r_addr + ROW_STRIDE;
                end
                CAPT: begin
                    if (r_loaded != 2'd3) r_loaded <= r_loaded + 2'd1;
                    if (r_loaded < 2'd2) begin
                        r_col  <= r_col + COORD_W'(1);
                        r_addr <= w_next_col_addr;
                    end
                end
                CALC: begin
                    if (r_cnt == CNT_W'(1)) begin
                        r_out_data <= dp_sobel_x_out;
                        r_out_x    <= r_col - COORD_W'(1);
                        r_out_y    <= r_row;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (w_row_end) begin
                            if (!w_last_row) begin
                                r_row      <= r_row + COORD_W'(1);
                                r_col      <= '0;
                                r_row_base <= r_row_base + ROW_STRIDE;
                                r_addr     <= r_row_base + ROW_STRIDE;
                                r_loaded   <= '0;
                            end
                        end else begin
                            r_col  <= r_col + COORD_W'(1);
                            r_addr <= w_next_col_addr;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        busy                  = (r_state != IDLE) && (r_state != DONE);
        done                  = (r_state == DONE);
        mem_rd                = w_mem_rd;
        mem_addr              = w_mem_rd ? r_addr : '0;
        // Memory data is only forwarded in the cycle after our own read, so
        // anything in flight across a reset never reaches the engine.
        dp_current_in         = r_rd_dly ? mem_rdata : '0;
        dp_tap_first          = r_first_dly;
        dp_left_intermediate  = w_i0;
        dp_right_intermediate = w_i2;
        out_valid             = (r_state == EMIT);
        out_data              = r_out_data;
        out_x                 = r_out_x;
        out_y                 = r_out_y;
    end

endmodule

// File: tb/tb_sobel_x_frame_sched.sv
// Self-checking bench for sobel_x_frame_sched: a 4x4 and a 3x3 instance, each with a
// frame memory and a column-sequential Sobel-X engine model (weights 1,2,1 per
// column; result = right - left). Expected results are pushed to a queue when a
// frame is started and popped as the scheduler emits them.
module tb_sobel_x_frame_sched;

    logic clk, rst, start4, start3, ready;

    logic       busy4, done4, rd4, tf4, valid4;
    logic [7:0] addr4, cur4, rdata4;
    logic [9:0] ci4, left4, right4, sob4, data4;
    logic [15:0] x4, y4;
    int         tc4;

    logic       busy3, done3, rd3, tf3, valid3;
    logic [7:0] addr3, cur3, rdata3;
    logic [9:0] ci3, left3, right3, sob3, data3;
    logic [15:0] x3, y3;
    int         tc3;

    logic [7:0] img [0:255];
    int n_checks = 0;
    int n_fail   = 0;
    bit sel;

    typedef struct {int x; int y; int d;} exp_t;
    exp_t exp_q[$];

    sobel_x_frame_sched #(.IMG_W(4), .IMG_H(4), .ADDR_W(8), .DP_LAT(1)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .busy(busy4), .done(done4),
        .mem_rd(rd4), .mem_addr(addr4), .mem_rdata(rdata4),
        .dp_current_in(cur4), .dp_tap_first(tf4), .dp_current_intermediate(ci4),
        .dp_left_intermediate(left4), .dp_right_intermediate(right4), .dp_sobel_x_out(sob4),
        .out_valid(valid4), .out_ready(ready), .out_data(data4), .out_x(x4), .out_y(y4));

    sobel_x_frame_sched #(.IMG_W(3), .IMG_H(3), .ADDR_W(8), .DP_LAT(1)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .busy(busy3), .done(done3),
        .mem_rd(rd3), .mem_addr(addr3), .mem_rdata(rdata3),
        .dp_current_in(cur3), .dp_tap_first(tf3), .dp_current_intermediate(ci3),
        .dp_left_intermediate(left3), .dp_right_intermediate(right3), .dp_sobel_x_out(sob3),
        .out_valid(valid3), .out_ready(ready), .out_data(data3), .out_x(x3), .out_y(y3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame memories (garbage when not read, to expose ungated data paths)
    always @(posedge clk) rdata4 <= rd4 ? img[addr4] : 8'hA5;
    always @(posedge clk) rdata3 <= rd3 ? img[addr3] : 8'h5A;

    // Engine models
    always @(posedge clk) begin
        if (tf4) begin ci4 <= {2'b00, cur4}; tc4 <= 1; end
        else if (tc4 == 1) begin ci4 <= ci4 + {1'b0, cur4, 1'b0}; tc4 <= 2; end
        else if (tc4 == 2) begin ci4 <= ci4 + {2'b00, cur4}; tc4 <= 0; end
        sob4 <= right4 - left4;
    end
    always @(posedge clk) begin
        if (tf3) begin ci3 <= {2'b00, cur3}; tc3 <= 1; end
        else if (tc3 == 1) begin ci3 <= ci3 + {1'b0, cur3, 1'b0}; tc3 <= 2; end
        else if (tc3 == 2) begin ci3 <= ci3 + {2'b00, cur3}; tc3 <= 0; end
        sob3 <= right3 - left3;
    end

    logic        s_valid, s_done, s_busy, s_rd;
    logic [9:0]  s_data;
    logic [15:0] s_x, s_y;
    assign s_valid = sel ? valid3 : valid4;
    assign s_done  = sel ? done3  : done4;
    assign s_busy  = sel ? busy3  : busy4;
    assign s_rd    = sel ? rd3    : rd4;
    assign s_data  = sel ? data3  : data4;
    assign s_x     = sel ? x3     : x4;
    assign s_y     = sel ? y3     : y4;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int colint(input int w, input int r, input int c);
        return int'(img[(r-1)*w+c]) + 2*int'(img[r*w+c]) + int'(img[(r+1)*w+c]);
    endfunction

    function automatic void push_frame(input int w, input int h);
        exp_t e;
        for (int y = 1; y <= h-2; y++) begin
            for (int x = 1; x <= w-2; x++) begin
                e.x = x;
                e.y = y;
                e.d = (colint(w, y, x+1) - colint(w, y, x-1)) & 32'h3ff;
                exp_q.push_back(e);
            end
        end
    endfunction

    task automatic run_frame(input bit s, input int w, input int h,
                             input int stall_idx, input bit extra_start);
        int acc_cnt, rd_cnt, stall_left, last_acc, cyc;
        bit finished, extra_done;
        exp_t e;
        acc_cnt = 0; rd_cnt = 0; stall_left = 5; last_acc = -10;
        finished = 0; extra_done = 0;
        sel = s;
        ready = 1'b1;
        push_frame(w, h);
        @(posedge clk); #1;
        if (s) start3 = 1'b1; else start4 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0; start4 = 1'b0;
        for (cyc = 0; cyc < 3000 && !finished; cyc++) begin
            if (extra_start && acc_cnt == 1 && !extra_done) begin
                start4 = 1'b1;
                extra_done = 1;
            end
            if (acc_cnt == stall_idx && s_valid && stall_left > 0) begin
                ready = 1'b0;
                stall_left--;
            end else begin
                ready = 1'b1;
            end
            @(negedge clk);
            if (cyc == 0) chk("busy_after_start", int'(s_busy), 1);
            if (s_rd) rd_cnt++;
            if (s_valid && !ready && exp_q.size() > 0) begin
                chk("stall_data", int'(s_data), exp_q[0].d);
                chk("stall_x", int'(s_x), exp_q[0].x);
                chk("stall_y", int'(s_y), exp_q[0].y);
                chk("stall_no_rd", int'(s_rd), 0);
            end
            if (s_valid && ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    $display("txn %0d: x=%0d y=%0d data=%0d (exp %0d,%0d,%0d)",
                             acc_cnt, s_x, s_y, s_data, e.x, e.y, e.d);
                    chk("out_x", int'(s_x), e.x);
                    chk("out_y", int'(s_y), e.y);
                    chk("out_data", int'(s_data), e.d);
                end
                acc_cnt++;
                last_acc = cyc;
            end
            if (s_done) begin
                chk("done_latency", cyc, last_acc + 1);
                finished = 1;
            end
            @(posedge clk); #1;
            start4 = 1'b0;
        end
        ready = 1'b1;
        if (!finished) chk("frame_timeout", 0, 1);
        chk("out_count", acc_cnt, (w-2)*(h-2));
        chk("mem_rd_count", rd_cnt, 3*w*(h-2));
        chk("queue_empty", exp_q.size(), 0);
        @(negedge clk);
        chk("busy_after_done", int'(s_busy), 0);
        chk("done_single_pulse", int'(s_done), 0);
    endtask

    initial begin
        int rd_seen, activity;
        rst = 1'b1; start4 = 1'b0; start3 = 1'b0; ready = 1'b1; sel = 1'b0;
        for (int i = 0; i < 256; i++) img[i] = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", int'(busy4), 0);
        chk("rst_done", int'(done4), 0);
        chk("rst_mem_rd", int'(rd4), 0);
        chk("rst_mem_addr", int'(addr4), 0);
        chk("rst_dp_in", int'(cur4), 0);
        chk("rst_tap_first", int'(tf4), 0);
        chk("rst_left", int'(left4), 0);
        chk("rst_right", int'(right4), 0);
        chk("rst_out_valid", int'(valid4), 0);
        chk("rst_out_data", int'(data4), 0);
        chk("rst_out_x", int'(x4), 0);
        chk("rst_out_y", int'(y4), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Flat image: all zeros expected
        for (int i = 0; i < 16; i++) img[i] = 8'd5;
        run_frame(0, 4, 4, -1, 0);

        // Horizontal ramp: pixel = 10*col
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) img[r*4+c] = 8'(10*c);
        run_frame(0, 4, 4, -1, 0);

        // Minimum 3x3 frame with random pixels
        for (int i = 0; i < 9; i++) img[i] = 8'($urandom_range(0, 255));
        run_frame(1, 3, 3, -1, 0);

        // Random 4x4 with backpressure on the second output
        for (int i = 0; i < 16; i++) img[i] = 8'($urandom_range(0, 255));
        run_frame(0, 4, 4, 1, 0);

        // start coincident with rst is ignored
        sel = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; start4 = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start4 = 1'b0;
        @(negedge clk);
        chk("start_with_rst_busy", int'(busy4), 0);
        chk("start_with_rst_rd", int'(rd4), 0);

        // Reset mid-row, after the second column capture
        for (int i = 0; i < 16; i++) img[i] = 8'($urandom_range(0, 255));
        @(posedge clk); #1;
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        rd_seen = 0;
        for (int i = 0; i < 200 && rd_seen < 6; i++) begin
            @(negedge clk);
            if (rd4) rd_seen++;
        end
        chk("rst_test_reads", rd_seen, 6);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", int'(busy4), 0);
        chk("midrst_mem_rd", int'(rd4), 0);
        chk("midrst_out_valid", int'(valid4), 0);
        exp_q.delete();

        // Replay the frame, with a start pulse while busy that must be ignored
        run_frame(0, 4, 4, -1, 1);
        activity = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy4 || valid4 || rd4) activity++;
        end
        chk("no_second_frame", activity, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
